// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM controller for LSB and instruction fetch; IO store stall enabled by MEMCTRL_IO_STALL_EN
module mem_ctrl #(
    parameter logic [31:0] IO_ADDR_MASK = 32'h00030000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        lsb_request,
    input  logic        lsb_load_or_store,
    input  logic [5:0]  lsb_op,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_data,
    output logic        lsb_mem_valid,
    output logic [31:0] lsb_mem_val,
    input  logic        if_request,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_inst
);
    localparam logic [5:0] LB = 6'd0, LH = 6'd1, LW = 6'd2, LBU = 6'd3, LHU = 6'd4, SB = 6'd5, SH = 6'd6, SW = 6'd7;
`ifdef MEMCTRL_IO_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    state_t state, state_n;
    logic        owner;
    logic [5:0]  op;
    logic [31:0] addr, data, buffer, word, result, addr_n;
    logic [2:0]  k, k_inc, len;
    logic        wr_q, cleared, accept, store_in, stall, stall_in;

    assign accept   = state == IDLE && !clear && (lsb_request || if_request);
    assign store_in = lsb_request && lsb_load_or_store;
    assign k_inc    = k + 3'd1;
    assign addr_n   = addr + {29'd0, k_inc};
    assign len      = !owner ? 3'd4
                    : (op == LB || op == LBU || op == SB) ? 3'd1
                    : (op == LH || op == LHU || op == SH) ? 3'd2 : 3'd4;
    assign word     = buffer | ({24'd0, mem_din} << {k - 3'd1, 3'b000});
    assign result   = op == LB  ? {{24{word[7]}}, word[7:0]}
                    : op == LH  ? {{16{word[15]}}, word[15:0]}
                    : op == LBU ? {24'd0, word[7:0]}
                    : op == LHU ? {16'd0, word[15:0]} : word;
    assign stall    = STALL_EN && (addr & IO_ADDR_MASK) == IO_ADDR_MASK && io_buffer_full;
    assign stall_in = STALL_EN && (lsb_addr & IO_ADDR_MASK) == IO_ADDR_MASK && io_buffer_full;
    assign mem_wr   = wr_q & rdy_in;

    // state register, frozen while rdy_in is low
    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else if (rdy_in) state <= state_n;
    end

    // next state: a read ends one cycle after its last address, a write after its last byte
    always_comb begin
        state_n = state;
        state_n = state == IDLE  ? (accept ? (store_in ? WRITE : READ) : IDLE)
                : state == READ  ? (clear ? IDLE : k == len ? DONE : READ)
                : state == WRITE ? (wr_q && k_inc == len ? DONE : WRITE)
                : IDLE;
    end

    // datapath: latch the access, stream bytes, assemble the load word and raise completion
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            owner         <= 1'b0;
            op            <= '0;
            addr          <= '0;
            data          <= '0;
            buffer        <= '0;
            k             <= '0;
            wr_q          <= 1'b0;
            cleared       <= 1'b0;
            mem_a         <= '0;
            mem_dout      <= '0;
            lsb_mem_valid <= 1'b0;
            lsb_mem_val   <= '0;
            if_valid      <= 1'b0;
            if_inst       <= '0;
        end else if (rdy_in) begin
            lsb_mem_valid <= 1'b0;
            if_valid      <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    owner    <= lsb_request;
                    op       <= lsb_op;
                    addr     <= lsb_request ? lsb_addr : if_addr;
                    mem_a    <= lsb_request ? lsb_addr : if_addr;
                    data     <= lsb_data;
                    mem_dout <= lsb_data[7:0];
                    buffer   <= '0;
                    k        <= '0;
                    cleared  <= 1'b0;
                    wr_q     <= store_in && !stall_in;
                end
                READ: if (!clear) begin
                    k      <= k_inc;
                    buffer <= word;
                    if (k_inc < len) mem_a <= addr_n;
                    if (k == len && owner) begin
                        lsb_mem_valid <= 1'b1;
                        lsb_mem_val   <= result;
                    end
                    if (k == len && !owner) begin
                        if_valid <= 1'b1;
                        if_inst  <= word;
                    end
                end
                WRITE: begin
                    cleared <= cleared | clear;
                    if (wr_q && k_inc == len) begin
                        wr_q          <= 1'b0;
                        lsb_mem_valid <= !(cleared || clear);
                        lsb_mem_val   <= '0;
                    end else if (wr_q) begin
                        k        <= k_inc;
                        mem_a    <= addr_n;
                        mem_dout <= 8'(data >> {k_inc, 3'b000});
                        wr_q     <= !stall;
                    end else begin
                        wr_q <= !stall;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller directly downstream of the load/store buffer; also serves instruction fetch.
- Arbitrates the two clients, one access at a time.
- Splits each access into 1/2/4 little-endian byte transfers on the 8-bit RAM port.
- Returns the assembled, extended load word or a store/fetch completion pulse.

Parameters:
- IO_ADDR_MASK, 32'h00030000, address is IO-mapped when (addr & IO_ADDR_MASK) == IO_ADDR_MASK.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global enable; low freezes all state
- clear  in  1  pipeline flush (branch mispredict)
- io_buffer_full  in  1  UART write buffer full
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  RAM write strobe (1 = write)
- lsb_request  in  1  LSB access request, held until completion seen
- lsb_load_or_store  in  1  0 = load, 1 = store
- lsb_op  in  6  const.v opcode: `Lb/`Lh/`Lw/`Lbu/`Lhu/`Sb/`Sh/`Sw
- lsb_addr  in  32  byte address
- lsb_data  in  32  store data; low bytes used
- lsb_mem_valid  out  1  one-cycle completion pulse to LSB
- lsb_mem_val  out  32  load result, valid with the pulse
- if_request  in  1  fetch request, held until if_valid seen
- if_addr  in  32  fetch address
- if_valid  out  1  one-cycle fetch completion pulse
- if_inst  out  32  fetched word

Behaviour:
- Reset (rst_in=1 at posedge):
  - State returns to IDLE.
  - mem_a=0, mem_dout=0, mem_wr=0.
  - lsb_mem_valid=0, lsb_mem_val=0, if_valid=0, if_inst=0.
  - Byte counter and assembly register cleared.
  - Reset overrides clear and rdy_in and aborts any access mid-flight, including a store mid-write.
- rdy_in=0: all registers hold. The mem_wr pin is driven as mem_wr_q & rdy_in, so no write occurs while frozen.
- Byte length N:
  - Lb/Lbu/Sb = 1; Lh/Lhu/Sh = 2; Lw/Sw = 4.
  - Fetch always N = 4.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - Accepts a request in cycle A. If both clients request, LSB wins; fetch waits.
  - Latches op, addr, data and owner; counter k = 0.
  - Load/fetch goes to READ; store goes to WRITE.
- Read timing:
  - mem_a = addr+k is visible in cycle A+1+k (k = 0..N-1), with mem_wr = 0.
  - The byte for mem_a at cycle t is on mem_din at t+1. Byte k lands in bits [8k+7:8k].
  - Completion registers visible at A+N+2, with state DONE.
  - Lb sign-extends bit 7, Lh bit 15; Lbu/Lhu zero-extend.
  - A word load or fetch completes at A+6.
- Write timing:
  - Cycle A+1+k: mem_a = addr+k, mem_dout = data[8k+7:8k], mem_wr = 1.
  - Cycle A+N+1: mem_wr = 0, lsb_mem_valid = 1 (lsb_mem_val = 0), state DONE.
- DONE:
  - Lasts exactly one cycle; the owner's valid pulse is high in it.
  - No request is accepted in DONE, since requesters drop their request one cycle after seeing valid.
  - Returns to IDLE.
- IO stall:
  - Applies to a store to an IO address.
  - In WRITE with io_buffer_full = 1, no byte is issued: mem_wr = 0 and k holds until it deasserts.
- clear at posedge:
  - READ (LSB or fetch): abort, go to IDLE, no valid pulse, mem_a holds.
  - IDLE: the same-cycle request is not accepted.
  - WRITE: the store runs to completion (it is committed), then enters DONE with lsb_mem_valid suppressed.
  - DONE: the pending pulse is already driven and is not retracted.
- Address wrap: addr+k wraps modulo 2^32.
- Unaligned addresses are legal; bytes are taken sequentially.

Optional Feature:
- Macro MEMCTRL_IO_STALL_EN.
  - Defined: IO stall as above.
  - Undefined: io_buffer_full is ignored; IO stores proceed at full rate.

Test Plan:
- Word load: RAM[0x100..0x103] = 78 56 34 12, Lw @0x100 accepted cycle A. Expect lsb_mem_valid at A+6 with lsb_mem_val = 0x12345678, and mem_wr = 0 throughout.
- Byte load: Lb @0x200 with RAM = 0x80 gives 0xFFFFFF80; Lbu gives 0x00000080. Lh @0x202 with bytes FE FF gives 0xFFFFFFFE.
- Halfword store: Sh @0x300, data 0xAABBCCDD. Expect writes 0x300 = DD at A+1, 0x301 = CC at A+2, no further mem_wr, and lsb_mem_valid at A+3.
- Arbitration: if_request and lsb_request both rise in the same cycle. LSB is served first; fetch is accepted only after the DONE cycle. The held request is not re-accepted during DONE.
- Flush: clear asserted mid-fetch (cycle A+3) gives no if_valid and IDLE next cycle. clear asserted during Sw gives all 4 bytes written and no lsb_mem_valid.
- IO stall (macro on): Sb @0x30000 with io_buffer_full = 1 for 5 cycles gives no mem_wr during that time. The write happens the cycle after it drops, and lsb_mem_valid follows one cycle later.
